// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Single-channel SPI master for a small word-addressed SPI memory (mode 0:
//   sclk idles low, mosi launched on the low phase, miso captured as sclk
//   rises). One transaction moves a 16-bit frame {addr[6:0], rw, data}
//   MSB-first. A transaction runs SETUP -> XFER -> HOLD -> GAP and then
//   returns to IDLE with a one-cycle done pulse.
//
// Parameters
//   HALF_PERIOD : clk cycles per sclk half-period (2..255)
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   transaction request, only looked at while idle
//   rw     in   1 = read, 0 = write
//   addr   in   7-bit word address
//   wdata  in   8-bit write data
//   busy   out  high while a transaction is in progress
//   done   out  one-cycle completion pulse (first IDLE cycle)
//   rdata  out  result of the most recent read
//   sclk   out  SPI clock, idle low
//   cs     out  SPI chip select, active low
//   mosi   out  SPI master out
//   miso   in   SPI master in
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int HALF_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(HALF_PERIOD - 32'sd1);
  localparam logic [3:0] BIT_LAST  = 4'd15;
  // Bit index of the first data bit (bit 9 of the frame, counted from 1).
  localparam logic [3:0] BIT_DATA0 = 4'd8;

  // Reads send an all-zero data byte so mosi stays quiet while the slave talks.
  function automatic logic [15:0] build_frame(input logic f_rw,
                                              input logic [6:0] f_addr,
                                              input logic [7:0] f_wdata);
    build_frame = {f_addr, f_rw, (f_rw ? 8'h00 : f_wdata)};
  endfunction

  state_t      r_state;
  logic [7:0]  r_div;
  logic [3:0]  r_bit;
  logic        r_gap_half;
  logic [15:0] r_shift;
  logic [7:0]  r_rx;
  logic        r_rw;
  logic        r_sclk;
  logic        r_cs;
  logic        r_mosi;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_rdata;

  state_t      w_state;
  logic [7:0]  w_div;
  logic [3:0]  w_bit;
  logic        w_gap_half;
  logic [15:0] w_shift;
  logic [7:0]  w_rx;
  logic        w_rw;
  logic        w_sclk;
  logic        w_cs;
  logic        w_mosi;
  logic        w_busy;
  logic        w_done;
  logic [7:0]  w_rdata;
  logic        w_div_last;

  assign w_div_last = (r_div == DIV_LAST);

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    w_state    = r_state;
    w_div      = r_div;
    w_bit      = r_bit;
    w_gap_half = r_gap_half;
    w_shift    = r_shift;
    w_rx       = r_rx;
    w_rw       = r_rw;
    w_sclk     = r_sclk;
    w_cs       = r_cs;
    w_mosi     = r_mosi;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_rdata    = r_rdata;

    case (r_state)
      S_IDLE: begin
        w_div      = 8'd0;
        w_bit      = 4'd0;
        w_gap_half = 1'b0;
        w_sclk     = 1'b0;
        w_cs       = 1'b1;
        w_mosi     = 1'b0;
        w_busy     = 1'b0;
        if (start) begin
          w_state = S_SETUP;
          w_busy  = 1'b1;
          w_cs    = 1'b0;
          w_rw    = rw;
          w_shift = build_frame(rw, addr, wdata);
          w_rx    = 8'h00;
        end else begin
          w_state = S_IDLE;
        end
      end

      S_SETUP: begin
        if (w_div_last) begin
          // First low phase of bit 1 starts here, so launch the MSB now.
          w_div   = 8'd0;
          w_state = S_XFER;
          w_mosi  = r_shift[15];
          w_shift = {r_shift[14:0], 1'b0};
        end else begin
          w_div = r_div + 8'd1;
        end
      end

      S_XFER: begin
        if (r_sclk) begin
          // r_div == 0 marks the cycle in which sclk went high.
          if ((r_div == 8'd0) && (r_bit >= BIT_DATA0)) begin
            w_rx = {r_rx[6:0], miso};
          end else begin
            w_rx = r_rx;
          end
          if (w_div_last) begin
            w_div  = 8'd0;
            w_sclk = 1'b0;
            if (r_bit == BIT_LAST) begin
              w_state = S_HOLD;
              w_mosi  = 1'b0;
            end else begin
              w_bit   = r_bit + 4'd1;
              w_mosi  = r_shift[15];
              w_shift = {r_shift[14:0], 1'b0};
            end
          end else begin
            w_div = r_div + 8'd1;
          end
        end else begin
          if (w_div_last) begin
            w_div  = 8'd0;
            w_sclk = 1'b1;
          end else begin
            w_div = r_div + 8'd1;
          end
        end
      end

      S_HOLD: begin
        if (w_div_last) begin
          w_div   = 8'd0;
          w_state = S_GAP;
          w_cs    = 1'b1;
          w_mosi  = 1'b0;
        end else begin
          w_div = r_div + 8'd1;
        end
      end

      S_GAP: begin
        // The gap is two divider periods; r_gap_half tells them apart.
        if (w_div_last) begin
          w_div = 8'd0;
          if (r_gap_half) begin
            w_state    = S_IDLE;
            w_gap_half = 1'b0;
            w_done     = 1'b1;
            w_busy     = 1'b0;
            if (r_rw) begin
              w_rdata = r_rx;
            end else begin
              w_rdata = r_rdata;
            end
          end else begin
            w_gap_half = 1'b1;
          end
        end else begin
          w_div = r_div + 8'd1;
        end
      end

      default: begin
        w_state    = S_IDLE;
        w_div      = 8'd0;
        w_bit      = 4'd0;
        w_gap_half = 1'b0;
        w_sclk     = 1'b0;
        w_cs       = 1'b1;
        w_mosi     = 1'b0;
        w_busy     = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Counters, shift registers and registered SPI/handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div      <= 8'd0;
      r_bit      <= 4'd0;
      r_gap_half <= 1'b0;
      r_shift    <= 16'h0000;
      r_rx       <= 8'h00;
      r_rw       <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs       <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rdata    <= 8'h00;
    end else begin
      r_div      <= w_div;
      r_bit      <= w_bit;
      r_gap_half <= w_gap_half;
      r_shift    <= w_shift;
      r_rx       <= w_rx;
      r_rw       <= w_rw;
      r_sclk     <= w_sclk;
      r_cs       <= w_cs;
      r_mosi     <= w_mosi;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_rdata    <= w_rdata;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign sclk  = r_sclk;
  assign cs    = r_cs;
  assign mosi  = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Drives spi_master (HALF_PERIOD = 4) against a behavioural SPI memory slave
//   and checks frames, timing and read data against expectations computed from
//   the transaction inputs.
// -----------------------------------------------------------------------------
module tb_spi_master;

  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned cyc = 0;

  // Bus observation
  int unsigned rise_total     = 0;
  int unsigned mosi_err_total = 0;
  int unsigned gap_total      = 0;
  logic        prev_sclk      = 1'b0;
  logic [15:0] cap_frame      = 16'h0000;

  // Behavioural SPI memory slave
  logic [7:0]  mem [128];
  logic [4:0]  sl_cnt   = 5'd0;
  logic [15:0] sl_frame = 16'h0000;
  logic [7:0]  sl_hdr   = 8'h00;
  logic        poke_en  = 1'b0;
  logic [6:0]  poke_a   = 7'd0;
  logic [7:0]  poke_d   = 8'h00;

  // Expectations
  logic [7:0]  ref_mem [128];
  logic [7:0]  model_rdata;
  int unsigned tx_t, tx_rb, tx_mb, tx_gb;
  logic [15:0] tx_frame;
  logic [7:0]  tx_rd;

  spi_master #(.HALF_PERIOD(HP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .rw    (rw),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .rdata (rdata),
    .sclk  (sclk),
    .cs    (cs),
    .mosi  (mosi),
    .miso  (miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the bus and play the SPI memory (mode 0) on falling clk edges.
  always @(negedge clk) begin
    prev_sclk <= sclk;
    if (cs && mosi) mosi_err_total <= mosi_err_total + 1;
    if (cs && busy) gap_total <= gap_total + 1;
    if (sclk && !prev_sclk) begin
      rise_total <= rise_total + 1;
      cap_frame  <= {cap_frame[14:0], mosi};
    end
    if (poke_en) mem[poke_a] <= poke_d;
    if (cs) begin
      sl_cnt <= 5'd0;
      miso   <= 1'b0;
    end else if (sclk && !prev_sclk) begin
      sl_frame <= {sl_frame[14:0], mosi};
      sl_cnt   <= sl_cnt + 5'd1;
      if (sl_cnt == 5'd7) sl_hdr <= {sl_frame[6:0], mosi};
      if (sl_cnt == 5'd15 && !sl_hdr[0]) mem[sl_hdr[7:1]] <= {sl_frame[6:0], mosi};
    end else if (!sclk && prev_sclk) begin
      if (sl_cnt >= 5'd8 && sl_cnt <= 5'd15 && sl_hdr[0])
        miso <= mem[sl_hdr[7:1]][3'(5'd15 - sl_cnt)];
      else
        miso <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic poke(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_a = a;
    poke_d = d;
    poke_en = 1'b1;
    ref_mem[a] = d;
    @(negedge clk);
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Called at a falling edge of a cycle in which the DUT is idle (or in its done cycle).
  task automatic issue(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_wd);
    rw = t_rw;
    addr = t_addr;
    wdata = t_wd;
    start = 1'b1;
    tx_t = cyc;
    tx_rb = rise_total;
    tx_mb = mosi_err_total;
    tx_gb = gap_total;
    tx_frame = {t_addr, t_rw, (t_rw ? 8'h00 : t_wd)};
    tx_rd = t_rw ? ref_mem[t_addr] : model_rdata;
    if (!t_rw) ref_mem[t_addr] = t_wd;
    model_rdata = tx_rd;
  endtask

  task automatic finish_txn(input bit mid_start, input bit chain);
    bit got;
    got = 1'b0;
    @(negedge clk);
    if (!chain) start = 1'b0;
    check("cs_low_t1", 32'(cs), 32'(1'b0));
    check("busy_t1", 32'(busy), 32'(1'b1));
    check("done_low_t1", 32'(done), 32'(1'b0));
    for (int i = 0; i < 40 * HP && !got; i++) begin
      if (mid_start && i == 18 * HP) start = 1'b1;
      else if (!chain) start = 1'b0;
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) begin
      check("done_timeout", 32'(1'b0), 32'(1'b1));
    end else begin
      check("done_cycle", cyc, tx_t + 36 * HP + 1);
      check("busy_at_done", 32'(busy), 32'(1'b0));
      check("cs_at_done", 32'(cs), 32'(1'b1));
      check("rdata", 32'(rdata), 32'(tx_rd));
      check("sclk_rises", rise_total - tx_rb, 32'd16);
      check("mosi_frame", 32'(cap_frame), 32'(tx_frame));
      check("mosi_when_cs_high", mosi_err_total - tx_mb, 32'd0);
      check("gap_cycles", gap_total - tx_gb, 2 * HP);
    end
    if (!chain) begin
      @(negedge clk);
      check("idle_after_done", 32'(busy), 32'(1'b0));
      check("done_one_cycle", 32'(done), 32'(1'b0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rw = 1'b0;
    addr = 7'd0;
    wdata = 8'h00;
    model_rdata = 8'h00;
    // start held high throughout reset must have no effect
    start = 1'b1;
    for (int a = 0; a < 128; a++) poke(7'(a), 8'($urandom_range(255)));
    repeat (2) @(negedge clk);
    check("rst_cs", 32'(cs), 32'(1'b1));
    check("rst_sclk", 32'(sclk), 32'(1'b0));
    check("rst_mosi", 32'(mosi), 32'(1'b0));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_done", 32'(done), 32'(1'b0));
    check("rst_rdata", 32'(rdata), 32'(8'h00));
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'(1'b0));
    check("idle_cs", 32'(cs), 32'(1'b1));

    // Write 0xA5 to 0x15: frame 0x2A,0xA5; done at t+145; rdata untouched.
    issue(1'b0, 7'h15, 8'hA5);
    finish_txn(1'b0, 1'b0);

    // Read 0x15 with the slave holding 0x3C: frame 0x2B,0x00; rdata 0x3C.
    poke(7'h15, 8'h3C);
    @(negedge clk);
    issue(1'b1, 7'h15, 8'h00);
    finish_txn(1'b0, 1'b0);

    // A start pulse during XFER is ignored.
    issue(1'b0, 7'h4E, 8'h96);
    finish_txn(1'b1, 1'b0);

    // Reset for one cycle after the 5th sclk rise aborts without done.
    begin
      int unsigned db;
      bit seen_done;
      issue(1'b1, 7'h2D, 8'h00);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 * HP && (rise_total - tx_rb) < 5; i++) @(negedge clk);
      check("rises_before_abort", rise_total - tx_rb, 32'd5);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_cs", 32'(cs), 32'(1'b1));
      check("abort_sclk", 32'(sclk), 32'(1'b0));
      check("abort_busy", 32'(busy), 32'(1'b0));
      check("abort_rdata", 32'(rdata), 32'(8'h00));
      model_rdata = 8'h00;
      seen_done = 1'b0;
      db = 0;
      for (int i = 0; i < 40 * HP; i++) begin
        @(negedge clk);
        if (done) seen_done = 1'b1;
        if (busy) db++;
      end
      check("abort_no_done", 32'(seen_done), 32'(1'b0));
      check("abort_stays_idle", db, 32'd0);
    end

    // Back-to-back: write 0x5A to 3, start still high in the done cycle, then read 3.
    @(negedge clk);
    issue(1'b0, 7'd3, 8'h5A);
    finish_txn(1'b0, 1'b1);
    issue(1'b1, 7'd3, 8'h00);
    finish_txn(1'b0, 1'b0);
    check("loopback_rdata", 32'(rdata), 32'(8'h5A));

    // Randomized transactions against the memory model.
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(3)) @(negedge clk);
      issue(1'($urandom_range(1)), 7'($urandom_range(127)), 8'($urandom_range(255)));
      finish_txn(1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 8: the number of clk cycles per sclk half-period; legal range is 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset that is synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: transaction request, sampled only while idle.
REQ-005 SHALL have port rw, input, 1 bit: 1 = read, 0 = write.
REQ-006 SHALL have port addr, input, 7 bits: word address in the SPI memory.
REQ-007 SHALL have port wdata, input, 8 bits: write data.
REQ-008 SHALL have port busy, output, 1 bit: high while a transaction is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port rdata, output, 8 bits: last read result.
REQ-011 SHALL have port sclk, output, 1 bit: SPI clock, idle low.
REQ-012 SHALL have port cs, output, 1 bit: SPI chip select, active-low.
REQ-013 SHALL have port mosi, output, 1 bit: SPI master out, slave in.
REQ-014 SHALL have port miso, input, 1 bit: SPI master in, slave out.

Function
REQ-015 SHALL implement states IDLE, SETUP, XFER, HOLD and GAP; all outputs are registered.
REQ-016 SHALL, in IDLE with start=1, latch rw/addr/wdata, set busy=1, and enter SETUP on the next cycle; in all other states start is ignored.
REQ-017 SHALL, when the start cycle is cycle t, drive cs=0 from t+1, with SETUP occupying HALF_PERIOD cycles at sclk=0.
REQ-018 SHALL shift a 16-bit frame MSB-first during XFER: frame = {addr[6:0], rw, D}, where D = wdata for writes and 8'h00 for reads.
REQ-019 SHALL, for each of the 16 bits, hold sclk=0 for HALF_PERIOD cycles with mosi valid, then sclk=1 for HALF_PERIOD cycles; mosi changes only at the start of a low phase.
REQ-020 SHALL sample miso on the clk cycle in which sclk rises, for bits 9..16 only, shifting it MSB-first into an internal read register.
REQ-021 SHALL spend HALF_PERIOD cycles in HOLD after the 16th falling edge, with cs=0 and sclk=0.
REQ-022 SHALL drive cs=1 in GAP, which lasts 2*HALF_PERIOD cycles, and then return to IDLE.
REQ-023 SHALL, on entry to IDLE, pulse done=1 for exactly one cycle and set busy=0 in that same cycle; done therefore occurs at cycle t+36*HALF_PERIOD+1.
REQ-024 SHALL, on a read, load rdata from the read register in the done cycle; on a write, leave rdata unchanged.
REQ-025 SHALL accept a start asserted in the done cycle, giving back-to-back transactions with the full GAP preserved.
REQ-026 SHALL drive mosi=0 whenever cs=1 and during the data byte of a read.
REQ-027 SHALL use internal counters as follows: the divider counts 0..HALF_PERIOD-1 and wraps; the bit counter counts 0..15 with no wrap beyond 15.

Reset
REQ-028 SHALL, with rst_n=0 at a clk edge, force state=IDLE, sclk=0, cs=1, mosi=0, busy=0, done=0, rdata=8'h00, and clear all counters.
REQ-029 SHALL, on reset mid-transaction, abort immediately with cs=1 on the next cycle, no done pulse, and rdata unchanged from its reset value.
REQ-030 SHALL ignore start while rst_n=0.

Verification
REQ-031 SHALL cover a write with HALF_PERIOD=4, addr=7'h15, wdata=8'hA5 -> mosi bytes 8'h2A then 8'hA5, 16 sclk rises, done at t+145, rdata unchanged.
REQ-032 SHALL cover a read of addr=7'h15 with a miso model returning 8'h3C after byte 1 -> mosi bytes 8'h2B then 8'h00, rdata=8'h3C in the done cycle.
REQ-033 SHALL cover start pulsed during XFER -> ignored: exactly one done pulse and 16 sclk rises.
REQ-034 SHALL cover rst_n=0 for one cycle after the 5th sclk rise -> cs=1, sclk=0, busy=0 next cycle; no done pulse.
REQ-035 SHALL cover start held high across the done cycle -> a second transaction begins, with cs high for exactly 2*HALF_PERIOD cycles between frames.
REQ-036 SHALL cover a loopback to a spiMemory instance: write 8'h5A to address 3, then read address 3 -> rdata=8'h5A.
